// File: rtl/counter_bank_rd.sv
// Per-channel pop counters with an indexed, registered read port.
// Supports wrap or saturate, optional clear-on-read and sticky overflow flags.
module counter_bank_rd #(
  parameter int NUM_CH    = 5,
  parameter int CNT_W     = 5,
  parameter int SATURATE  = 0,
  parameter int CLR_ON_RD = 0,
  localparam int IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              idle,
  input  logic              req,
  input  logic [IDX_W-1:0]  idx,
  input  logic [NUM_CH-1:0] pop,
  output logic              valid,
  output logic [CNT_W-1:0]  data_out,
  output logic              rd_err,
  output logic [NUM_CH-1:0] ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W:0]   NUM_CH_L = (IDX_W+1)'(NUM_CH);

  logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0]            ovf_q, ovf_d;
  logic [CNT_W-1:0]             data_q, data_d;
  logic                         valid_q, valid_d;
  logic                         rd_err_q, rd_err_d;
  logic                         rd_acc_s, idx_ok_s;
  logic [NUM_CH-1:0]            sel_s, at_max_s, clr_s;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt_inc_s;

  assign rd_acc_s = req & idle;
  assign idx_ok_s = ({1'b0, idx} < NUM_CH_L);

  // Next-state for counters, overflow flags and the read response
  always_comb begin
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    data_d    = '0;
    sel_s     = '0;
    at_max_s  = '0;
    clr_s     = '0;
    cnt_inc_s = cnt_q;
    for (int i = 0; i < NUM_CH; i++) begin
      sel_s[i]    = rd_acc_s && idx_ok_s && (idx == IDX_W'(i));
      at_max_s[i] = (cnt_q[i] == CNT_MAX);
      clr_s[i]    = (CLR_ON_RD != 0) && sel_s[i];
      if (!pop[i]) begin
        cnt_inc_s[i] = cnt_q[i];
      end else if (at_max_s[i]) begin
        cnt_inc_s[i] = (SATURATE != 0) ? CNT_MAX : {CNT_W{1'b0}};
      end else begin
        cnt_inc_s[i] = cnt_q[i] + CNT_ONE;
      end
      // A clear loads the simultaneous pop so it is not lost; a new overflow beats the clear.
      cnt_d[i] = clr_s[i] ? {{(CNT_W-1){1'b0}}, pop[i]} : cnt_inc_s[i];
      ovf_d[i] = (pop[i] && at_max_s[i]) || (ovf_q[i] && !clr_s[i]);
      data_d   = data_d | (sel_s[i] ? cnt_q[i] : {CNT_W{1'b0}});
    end
    valid_d  = rd_acc_s;
    rd_err_d = rd_acc_s && !idx_ok_s;
  end

  // State and response registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      ovf_q    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      rd_err_q <= rd_err_d;
    end
  end

  assign valid    = valid_q;
  assign data_out = data_q;
  assign rd_err   = rd_err_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_counter_bank_rd.sv
// Scoreboard bench: three instances (wrap, saturate, clear-on-read) with
// directed stimulus; a negedge monitor pops expected responses as valid appears.
module tb_counter_bank_rd;

  typedef struct {
    int cyc;
    int data;
    int err;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       idle_s  [3];
  logic       req_s   [3];
  logic [2:0] idx_s   [3];
  logic [4:0] pop_s   [3];
  logic       valid_w [3];
  logic [4:0] data_w  [3];
  logic       err_w   [3];
  logic [4:0] ovf_w   [3];

  exp_t exp_q [3][$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errs = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  counter_bank_rd #(.NUM_CH(5), .CNT_W(5), .SATURATE(0), .CLR_ON_RD(0)) u_wrap (
    .clk(clk), .reset(reset), .idle(idle_s[0]), .req(req_s[0]), .idx(idx_s[0]),
    .pop(pop_s[0]), .valid(valid_w[0]), .data_out(data_w[0]), .rd_err(err_w[0]), .ovf(ovf_w[0]));

  counter_bank_rd #(.NUM_CH(5), .CNT_W(5), .SATURATE(1), .CLR_ON_RD(0)) u_sat (
    .clk(clk), .reset(reset), .idle(idle_s[1]), .req(req_s[1]), .idx(idx_s[1]),
    .pop(pop_s[1]), .valid(valid_w[1]), .data_out(data_w[1]), .rd_err(err_w[1]), .ovf(ovf_w[1]));

  counter_bank_rd #(.NUM_CH(5), .CNT_W(5), .SATURATE(0), .CLR_ON_RD(1)) u_clr (
    .clk(clk), .reset(reset), .idle(idle_s[2]), .req(req_s[2]), .idx(idx_s[2]),
    .pop(pop_s[2]), .valid(valid_w[2]), .data_out(data_w[2]), .rd_err(err_w[2]), .ovf(ovf_w[2]));

  task automatic chk(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Monitor: compares every presented response with the scoreboard head
  always @(negedge clk) begin
    if (!reset) begin
      for (int d = 0; d < 3; d++) begin
        if (valid_w[d]) begin
          if (exp_q[d].size() == 0) begin
            chk($sformatf("unexpected_valid_dut%0d", d), 1, 0);
          end else begin
            exp_t e;
            e = exp_q[d].pop_front();
            chk($sformatf("resp_data_dut%0d", d), int'(data_w[d]), e.data);
            chk($sformatf("resp_err_dut%0d", d), int'(err_w[d]), e.err);
            chk($sformatf("resp_cycle_dut%0d", d), cyc, e.cyc);
          end
        end else begin
          chk($sformatf("idle_outputs_dut%0d", d), int'({err_w[d], data_w[d]}), 0);
          if (exp_q[d].size() != 0 && exp_q[d][0].cyc <= cyc) begin
            void'(exp_q[d].pop_front());
            chk($sformatf("missing_resp_dut%0d", d), 0, 1);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int d, input int ix, input int ed, input int ee);
    exp_t e;
    req_s[d]  = 1'b1;
    idle_s[d] = 1'b1;
    idx_s[d]  = ix[2:0];
    e.cyc = cyc + 1;
    e.data = ed;
    e.err = ee;
    exp_q[d].push_back(e);
  endtask

  task automatic read1(input int d, input int ix, input int ed, input int ee);
    issue(d, ix, ed, ee);
    tick();
    req_s[d] = 1'b0;
  endtask

  task automatic pulses(input int d, input logic [4:0] pattern, input int n);
    pop_s[d] = pattern;
    repeat (n) tick();
    pop_s[d] = 5'b00000;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int d = 0; d < 3; d++) exp_q[d].delete();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 3; d++) begin
      idle_s[d] = 1'b1;
      req_s[d]  = 1'b0;
      idx_s[d]  = 3'd0;
      pop_s[d]  = 5'b00000;
    end
    #3;
    for (int d = 0; d < 3; d++)
      chk($sformatf("por_state_dut%0d", d), int'({valid_w[d], err_w[d], data_w[d], ovf_w[d]}), 0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset mid-cycle with pops running and a response in flight
    for (int d = 0; d < 3; d++) pop_s[d] = 5'b11111;
    tick();
    tick();
    req_s[0] = 1'b1;
    idx_s[0] = 3'd0;
    tick();
    for (int d = 0; d < 3; d++) pop_s[d] = 5'b00000;
    req_s[0] = 1'b0;
    #1;
    chk("inflight_before_reset", int'({valid_w[0], data_w[0]}), 32 + 2);
    #1;
    reset = 1'b1;
    for (int d = 0; d < 3; d++) exp_q[d].delete();
    #1;
    for (int d = 0; d < 3; d++)
      chk($sformatf("async_reset_dut%0d", d), int'({valid_w[d], err_w[d], data_w[d], ovf_w[d]}), 0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    for (int d = 0; d < 3; d++) issue(d, 0, 0, 0);
    tick();
    for (int d = 0; d < 3; d++) req_s[d] = 1'b0;
    tick();

    // Count and non-destructive read
    pulses(0, 5'b00100, 7);
    read1(0, 2, 7, 0);
    tick();
    read1(0, 2, 7, 0);
    tick();

    // Wrap vs saturate: 33 pops on channel 0
    pop_s[0] = 5'b00001;
    pop_s[1] = 5'b00001;
    repeat (33) tick();
    pop_s[0] = 5'b00000;
    pop_s[1] = 5'b00000;
    chk("ovf_wrap", int'(ovf_w[0]), 1);
    chk("ovf_sat", int'(ovf_w[1]), 1);
    issue(0, 0, 1, 0);
    issue(1, 0, 31, 0);
    tick();
    req_s[0] = 1'b0;
    req_s[1] = 1'b0;
    tick();

    // Clear-on-read with a simultaneous pop
    pulses(2, 5'b00010, 4);
    pop_s[2] = 5'b00010;
    read1(2, 1, 4, 0);
    pop_s[2] = 5'b00000;
    tick();
    read1(2, 1, 1, 0);
    tick();
    chk("clr_ovf_clear", int'(ovf_w[2]), 0);

    // Overflow flag cleared by read; set wins when the read edge overflows again
    pulses(2, 5'b01000, 32);
    chk("clr_ovf_set", int'(ovf_w[2]), 8);
    read1(2, 3, 0, 0);
    tick();
    chk("clr_ovf_cleared_by_read", int'(ovf_w[2]), 0);
    pulses(2, 5'b01000, 31);
    pop_s[2] = 5'b01000;
    read1(2, 3, 31, 0);
    pop_s[2] = 5'b00000;
    tick();
    chk("clr_set_wins", int'(ovf_w[2]), 8);
    read1(2, 6, 0, 1);
    tick();
    chk("bad_idx_ovf_kept", int'(ovf_w[2]), 8);
    read1(2, 3, 1, 0);
    tick();

    // Gating by idle and invalid index
    pulses(2, 5'b10000, 2);
    req_s[2]  = 1'b1;
    idle_s[2] = 1'b0;
    idx_s[2]  = 3'd4;
    tick();
    tick();
    chk("gated_valid", int'(valid_w[2]), 0);
    req_s[2]  = 1'b0;
    idle_s[2] = 1'b1;
    read1(2, 4, 2, 0);
    tick();
    read1(0, 6, 0, 1);
    tick();
    read1(0, 2, 7, 0);
    read1(0, 0, 1, 0);
    tick();

    // Streaming: counters 1..5, five back-to-back reads
    do_reset();
    for (int k = 0; k < 5; k++) begin
      pop_s[0] = 5'b11111 & (5'b11111 << k);
      tick();
    end
    pop_s[0] = 5'b00000;
    for (int k = 0; k < 5; k++) begin
      issue(0, k, k + 1, 0);
      tick();
    end
    req_s[0] = 1'b0;
    repeat (3) tick();

    chk("scoreboard_drained", exp_q[0].size() + exp_q[1].size() + exp_q[2].size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
